// File: rtl/exu_disp_pkg.sv
// Shared core package: opcode constants, opcode width and dispatcher FSM states.
package exu_disp_pkg;

    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OPCODE_LOAD     = 7'h03;
    localparam logic [OPC_W-1:0] OPCODE_MISC_MEM = 7'h0F;
    localparam logic [OPC_W-1:0] OPCODE_OP_IMM   = 7'h13;
    localparam logic [OPC_W-1:0] OPCODE_AUIPC    = 7'h17;
    localparam logic [OPC_W-1:0] OPCODE_STORE    = 7'h23;
    localparam logic [OPC_W-1:0] OPCODE_OP       = 7'h33;
    localparam logic [OPC_W-1:0] OPCODE_LUI      = 7'h37;
    localparam logic [OPC_W-1:0] OPCODE_BRANCH   = 7'h63;
    localparam logic [OPC_W-1:0] OPCODE_JALR     = 7'h67;
    localparam logic [OPC_W-1:0] OPCODE_JAL      = 7'h6F;
    localparam logic [OPC_W-1:0] OPCODE_SYSTEM   = 7'h73;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } disp_state_e;

endpackage

// File: rtl/exu_disp_dec.sv
// Opcode-to-channel lookup: one-hot lowest-index matching channel plus hit flag.
import exu_disp_pkg::*;

module exu_disp_dec #(
    parameter int                                  CHN_NUM     = 4,
    parameter int                                  OPC_PER_CHN = 4,
    parameter logic [CHN_NUM*OPC_PER_CHN*OPC_W-1:0] OPC_MAP    = '0
) (
    input  logic [OPC_W-1:0]   i_opc,
    output logic [CHN_NUM-1:0] o_match,
    output logic               o_hit
);

    logic [CHN_NUM-1:0] w_raw;

    // A zero slot is an unused entry and never matches.
    always_comb begin
        w_raw = '0;
        for (int c = 0; c < CHN_NUM; c++) begin
            for (int s = 0; s < OPC_PER_CHN; s++) begin
                if ((OPC_MAP[(c*OPC_PER_CHN+s)*OPC_W +: OPC_W] != '0) &&
                    (OPC_MAP[(c*OPC_PER_CHN+s)*OPC_W +: OPC_W] == i_opc)) begin
                    w_raw[c] = 1'b1;
                end
            end
        end
    end

    assign o_match = w_raw & (~w_raw + CHN_NUM'(1));
    assign o_hit   = |w_raw;

endmodule

// File: rtl/exu_disp.sv
// Execute-stage dispatcher: routes an instruction to one handler channel and retires it.
// Optional watchdog on multi-cycle channels enabled by EXU_DISP_WDOG_EN.
import exu_disp_pkg::*;

module exu_disp #(
    parameter int                                  CHN_NUM     = 4,
    parameter int                                  OPC_PER_CHN = 4,
    parameter logic [CHN_NUM*OPC_PER_CHN*OPC_W-1:0] OPC_MAP    = '0,
    parameter logic [CHN_NUM-1:0]                   CHN_1CYC   = '1,
    parameter int                                  TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_vld,
    input  logic [31:0]        ex_ir,
    output logic               ex_rdy,
    output logic               ex_illegal,
    output logic [CHN_NUM-1:0] chn_vld,
    input  logic [CHN_NUM-1:0] chn_rdy,
    input  logic [CHN_NUM-1:0] chn_done,
    output logic [CHN_NUM-1:0] chn_sel,
    output logic [31:0]        chn_ir,
    output logic               busy,
    output logic [31:0]        ret_cnt,
    output logic               err
);

    localparam int CW = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;

    if (CHN_NUM < 1 || CHN_NUM > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("exu_disp: unsupported CHN_NUM or TIMEOUT_CYC");
    end

    disp_state_e        r_state;
    disp_state_e        w_nxt;
    logic [CW-1:0]      r_chn;
    logic [CW-1:0]      w_chn_nxt;
    logic [CW-1:0]      w_acc_idx;
    logic [31:0]        r_ret_cnt;
    logic [CHN_NUM-1:0] w_match;
    logic [CHN_NUM-1:0] w_own;
    logic               w_hit;
    logic               w_done;
    logic               w_expire;

    exu_disp_dec #(
        .CHN_NUM     (CHN_NUM),
        .OPC_PER_CHN (OPC_PER_CHN),
        .OPC_MAP     (OPC_MAP)
    ) u_dec (
        .i_opc   (ex_ir[OPC_W-1:0]),
        .o_match (w_match),
        .o_hit   (w_hit)
    );

    always_comb begin
        w_acc_idx = '0;
        w_own     = '0;
        for (int c = 0; c < CHN_NUM; c++) begin
            if (w_match[c]) w_acc_idx = CW'(c);
            w_own[c] = (r_chn == CW'(c));
        end
    end

    assign w_done = |(chn_done & w_own);

`ifdef EXU_DISP_WDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_wdog;

    assign w_expire = (r_state == ST_WAIT) &&
                      (r_wdog == TW'(TIMEOUT_CYC - 1));

    // Counts WAIT cycles already spent; cleared whenever WAIT is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == ST_WAIT && w_nxt == ST_WAIT) begin
            r_wdog <= r_wdog + TW'(1);
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Outputs are gated by rst so an abandoned WAIT never retires.
    always_comb begin
        w_nxt      = r_state;
        w_chn_nxt  = r_chn;
        ex_rdy     = 1'b0;
        ex_illegal = 1'b0;
        err        = 1'b0;
        chn_vld    = '0;
        chn_sel    = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_vld && w_hit) begin
                        chn_vld = w_match;
                        chn_sel = w_match;
                        if (|(chn_rdy & w_match)) begin
                            if (|(CHN_1CYC & w_match)) begin
                                ex_rdy = 1'b1;
                            end else begin
                                w_nxt     = ST_WAIT;
                                w_chn_nxt = w_acc_idx;
                            end
                        end
                    end else if (ex_vld) begin
                        ex_rdy     = 1'b1;
                        ex_illegal = 1'b1;
                    end
                end
                ST_WAIT: begin
                    chn_sel = w_own;
                    if (w_done) begin
                        ex_rdy = 1'b1;
                        w_nxt  = ST_IDLE;
                    end else if (w_expire) begin
                        ex_rdy = 1'b1;
                        err    = 1'b1;
                        w_nxt  = ST_IDLE;
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_chn     <= '0;
            r_ret_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            r_chn   <= w_chn_nxt;
            if (ex_rdy) r_ret_cnt <= r_ret_cnt + 32'd1;
        end
    end

    assign busy    = !rst && (r_state == ST_WAIT);
    assign chn_ir  = ex_ir;
    assign ret_cnt = r_ret_cnt;

endmodule

// File: doc/exu_disp.md
EXU_DISP -- requirements
Module: exu_disp

Interface
REQ-001 SHALL have parameter CHN_NUM, default 4, meaning number of handler channels (1..8).
REQ-002 SHALL have parameter OPC_PER_CHN, default 4, meaning opcode slots per channel.
REQ-003 SHALL have parameter OPC_MAP, default all-zero, meaning packed CHN_NUM*OPC_PER_CHN*7-bit opcode table; slot value 7'h00 means unused.
REQ-004 SHALL have parameter CHN_1CYC, default all-ones, meaning CHN_NUM-bit mask of channels that complete on acceptance.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, meaning watchdog limit in cycles.
REQ-006 Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- ex_vld  in  1  instruction valid.
- ex_ir  in  32  instruction; opcode = ex_ir[6:0].
- ex_rdy  out  1  instruction retired this cycle.
- ex_illegal  out  1  retiring opcode matched no channel.
- chn_vld  out  CHN_NUM  one-hot issue request.
- chn_rdy  in  CHN_NUM  channel accepts.
- chn_done  in  CHN_NUM  multi-cycle completion pulse.
- chn_sel  out  CHN_NUM  one-hot owner, drives GPR mux select.
- chn_ir  out  32  instruction to channels.
- busy  out  1  FSM not IDLE.
- ret_cnt  out  32  retired-instruction count.
- err  out  1  watchdog expiry pulse.

Function
REQ-007 SHALL decode the channel as the lowest-index channel having any OPC_MAP slot equal to the opcode.
REQ-008 SHALL have FSM states IDLE and WAIT.
REQ-009 In IDLE with ex_vld and a match c, SHALL drive chn_vld[c]=1 and chn_sel[c]=1 combinationally.
REQ-010 In IDLE with ex_vld and no match, SHALL drive ex_rdy=1 and ex_illegal=1 in the same cycle, with no chn_vld.
REQ-011 On chn_rdy[c] with CHN_1CYC[c]=1, SHALL drive ex_rdy=1 in the same cycle and remain in IDLE.
REQ-012 On chn_rdy[c] with CHN_1CYC[c]=0, SHALL latch c and move to WAIT next cycle; ex_rdy SHALL stay 0.
REQ-013 In WAIT, SHALL hold chn_sel at the latched c, hold chn_vld=0, and ignore chn_done of other channels.
REQ-014 In WAIT, on chn_done[c], SHALL drive ex_rdy=1 that cycle and return to IDLE.
REQ-015 SHALL ignore chn_done during the IDLE acceptance cycle.
REQ-016 Requester SHALL hold ex_vld/ex_ir stable until ex_rdy; chn_ir SHALL equal ex_ir.
REQ-017 ret_cnt SHALL increment by 1 on every ex_rdy, including illegal and timeout retirements, and wrap 2^32-1 to 0.
REQ-018 chn_vld and chn_sel SHALL be all-zero when ex_vld=0 in IDLE.

Reset
REQ-019 rst SHALL force state IDLE, latched channel 0, ret_cnt 0 and watchdog counter 0.
REQ-020 During and after reset, ex_rdy, ex_illegal, chn_vld, chn_sel, busy and err SHALL be 0 until new stimulus.
REQ-021 rst asserted in WAIT SHALL abandon the instruction without an ex_rdy pulse.

Configuration
REQ-022 With EXU_DISP_WDOG_EN defined, SHALL count cycles in WAIT; on reaching TIMEOUT_CYC without chn_done, SHALL pulse err=1 and ex_rdy=1 together and return to IDLE.
REQ-023 With EXU_DISP_WDOG_EN defined, chn_done in the expiry cycle SHALL take precedence, retiring normally with err=0.
REQ-024 Without EXU_DISP_WDOG_EN, no counter SHALL exist, err SHALL be tied 0, and WAIT SHALL persist indefinitely.

Structure
REQ-025 The FSM state enum and the opcode width constant SHALL live in the shared core package alongside the existing OPCODE_* constants.
REQ-026 The opcode-to-channel lookup SHALL be one sub-module, exu_disp_dec (opcode in, one-hot match plus hit out).

Verification
REQ-027 OPC_MAP ch0={0x33,0x13}, CHN_1CYC=4'b0001; ex_ir opcode 0x33, chn_rdy[0]=1 -> chn_vld=0001 and ex_rdy=1 same cycle, ret_cnt 0->1.
REQ-028 Ch1={0x03,0x23}, multi-cycle; opcode 0x03 accepted, chn_done[1] 5 cycles later -> busy=1 for 5 cycles, ex_rdy single pulse on done cycle.
REQ-029 Opcode 0x37 unmapped -> ex_rdy=1 and ex_illegal=1 in the same cycle, chn_vld=0.
REQ-030 WDOG_EN, TIMEOUT_CYC=8, no chn_done -> err and ex_rdy pulse in the 8th WAIT cycle; next cycle busy=0.
REQ-031 Overlapping map (0x33 on ch0 and ch2) -> ch0 selected; rst pulsed in WAIT -> busy=0 and ret_cnt=0 next cycle, no ex_rdy.
REQ-032 Preload ret_cnt to 0xFFFFFFFF via force, retire one -> ret_cnt=0.
